turn_timer_ctrl: RTL and testbench

Turn controller that sits on the other end of the 10-second turn timer's interface. It owns the timer's reset, consumes its `done` pulse and second count, and alternates turns between two players. On a timeout it either requests an automatic move or declares a forfeit. It drives the VGA status overlay with the current player, the seconds remaining and the game result.

---
 rtl/turn_timer_ctrl_if.sv | 52 +++++
 rtl/turn_timer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_turn_timer_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_timer_ctrl_if.sv
// Signal bundle between the turn controller and its environment (board logic, turn timer,
// VGA status overlay). The controller connects through the slave modport.
interface turn_timer_ctrl_if;
    logic       start_in;
    logic       move_valid_in;
    logic       game_over_in;
    logic       timer_done_in;
    logic [3:0] timer_count_in;
    logic       auto_move_ack_in;
    logic       timer_rst_out;
    logic       auto_move_req_out;
    logic       player_out;
    logic [3:0] time_left_out;
    logic [3:0] turn_count_out;
    logic       forfeit_out;
    logic       winner_out;
    logic       warn_out;

    modport master (
        output start_in,
        output move_valid_in,
        output game_over_in,
        output timer_done_in,
        output timer_count_in,
        output auto_move_ack_in,
        input  timer_rst_out,
        input  auto_move_req_out,
        input  player_out,
        input  time_left_out,
        input  turn_count_out,
        input  forfeit_out,
        input  winner_out,
        input  warn_out
    );

    modport slave (
        input  start_in,
        input  move_valid_in,
        input  game_over_in,
        input  timer_done_in,
        input  timer_count_in,
        input  auto_move_ack_in,
        output timer_rst_out,
        output auto_move_req_out,
        output player_out,
        output time_left_out,
        output turn_count_out,
        output forfeit_out,
        output winner_out,
        output warn_out
    );
endinterface

// File: rtl/turn_timer_ctrl.sv
// Two-player turn controller driving a 10 s turn timer; timeouts request an auto move or forfeit.
// Optional low-time warning output is built only when TURN_WARN_EN is defined.
module turn_timer_ctrl #(
    parameter int unsigned MAX_TIMEOUTS = 2,
    parameter int unsigned WARN_SECS    = 3
) (
    input logic              clk_in,
    input logic              rst_in,
    turn_timer_ctrl_if.slave bus
);

    if (MAX_TIMEOUTS == 0 || MAX_TIMEOUTS > 3) begin : g_bad_max_timeouts
        $error("MAX_TIMEOUTS must be in 1..3");
    end
    if (WARN_SECS > 10) begin : g_bad_warn_secs
        $error("WARN_SECS must be in 0..10");
    end

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StAuto,
        StSwitch,
        StDone
    } state_e;

    localparam logic [1:0] MaxStreak = 2'(MAX_TIMEOUTS);

    state_e          state_q;
    logic            timer_rst_q;
    logic            auto_req_q;
    logic            player_q;
    logic [3:0]      time_left_q;
    logic [3:0]      turn_count_q;
    logic            forfeit_q;
    logic            winner_q;
    logic [1:0][1:0] streak_q;

    logic [3:0] count_sat;
    logic [3:0] run_left;
    logic [1:0] cur_streak;
    logic [1:0] streak_inc;
    logic       forfeit_hit;
    logic [3:0] turn_inc;

    always_comb begin
        count_sat   = (bus.timer_count_in > 4'd9) ? 4'd9 : bus.timer_count_in;
        run_left    = 4'd10 - count_sat;
        cur_streak  = streak_q[player_q];
        streak_inc  = (cur_streak == 2'd3) ? 2'd3 : cur_streak + 2'd1;
        forfeit_hit = (streak_inc == MaxStreak);
        turn_inc    = (turn_count_q >= 4'd9) ? 4'd9 : turn_count_q + 4'd1;
    end

`ifdef TURN_WARN_EN
    localparam logic [3:0] WarnLvl = 4'(WARN_SECS);

    logic warn_q;
    logic warn_hit;

    assign warn_hit = (run_left <= WarnLvl);
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            timer_rst_q  <= 1'b1;
            auto_req_q   <= 1'b0;
            player_q     <= 1'b0;
            time_left_q  <= 4'd10;
            turn_count_q <= 4'd0;
            forfeit_q    <= 1'b0;
            winner_q     <= 1'b0;
            streak_q     <= '0;
`ifdef TURN_WARN_EN
            warn_q       <= 1'b0;
`endif
        end else begin
            // Overlay shows the full 10 s whenever the next state is not RUN.
            time_left_q <= 4'd10;
`ifdef TURN_WARN_EN
            warn_q      <= 1'b0;
`endif
            unique case (state_q)
                StIdle, StDone: begin
                    timer_rst_q <= 1'b1;
                    if (bus.start_in) begin
                        state_q      <= StArm;
                        player_q     <= 1'b0;
                        turn_count_q <= 4'd0;
                        streak_q     <= '0;
                        forfeit_q    <= 1'b0;
                    end
                end
                StArm: begin
                    state_q     <= StRun;
                    timer_rst_q <= 1'b0;
                    time_left_q <= run_left;
`ifdef TURN_WARN_EN
                    warn_q      <= warn_hit;
`endif
                end
                StRun: begin
                    if (bus.game_over_in) begin
                        state_q     <= StDone;
                        timer_rst_q <= 1'b1;
                    end else if (bus.move_valid_in) begin
                        state_q            <= StSwitch;
                        timer_rst_q        <= 1'b1;
                        streak_q[player_q] <= 2'd0;
                    end else if (bus.timer_done_in) begin
                        streak_q[player_q] <= streak_inc;
                        timer_rst_q        <= 1'b1;
                        if (forfeit_hit) begin
                            state_q   <= StDone;
                            forfeit_q <= 1'b1;
                            winner_q  <= ~player_q;
                        end else begin
                            state_q    <= StAuto;
                            auto_req_q <= 1'b1;
                        end
                    end else begin
                        time_left_q <= run_left;
`ifdef TURN_WARN_EN
                        warn_q      <= warn_hit;
`endif
                    end
                end
                StAuto: begin
                    timer_rst_q <= 1'b1;
                    if (bus.game_over_in) begin
                        state_q    <= StDone;
                        auto_req_q <= 1'b0;
                    end else if (bus.auto_move_ack_in) begin
                        state_q    <= StSwitch;
                        auto_req_q <= 1'b0;
                    end
                end
                StSwitch: begin
                    state_q      <= StArm;
                    timer_rst_q  <= 1'b1;
                    player_q     <= ~player_q;
                    turn_count_q <= turn_inc;
                end
                default: begin
                    state_q     <= StIdle;
                    timer_rst_q <= 1'b1;
                    auto_req_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.timer_rst_out     = timer_rst_q;
    assign bus.auto_move_req_out = auto_req_q;
    assign bus.player_out        = player_q;
    assign bus.time_left_out     = time_left_q;
    assign bus.turn_count_out    = turn_count_q;
    assign bus.forfeit_out       = forfeit_q;
    assign bus.winner_out        = winner_q;
`ifdef TURN_WARN_EN
    assign bus.warn_out          = warn_q;
`else
    assign bus.warn_out          = 1'b0;
`endif

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Directed bench for turn_timer_ctrl: turn switching, auto moves, forfeits, warning and reset.
module tb_turn_timer_ctrl;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef TURN_WARN_EN
    localparam logic WarnEn = 1'b1;
`else
    localparam logic WarnEn = 1'b0;
`endif

    turn_timer_ctrl_if bus ();

    turn_timer_ctrl #(
        .MAX_TIMEOUTS(2),
        .WARN_SECS   (3)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst                  = 1'b1;
        bus.start_in         = 1'b0;
        bus.move_valid_in    = 1'b0;
        bus.game_over_in     = 1'b0;
        bus.timer_done_in    = 1'b0;
        bus.timer_count_in   = 4'd0;
        bus.auto_move_ack_in = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_timer_rst", bus.timer_rst_out, 1);
        chk("rst_auto_req", bus.auto_move_req_out, 0);
        chk("rst_player", bus.player_out, 0);
        chk("rst_time_left", bus.time_left_out, 10);
        chk("rst_turn_count", bus.turn_count_out, 0);
        chk("rst_forfeit", bus.forfeit_out, 0);
        chk("rst_winner", bus.winner_out, 0);
        chk("rst_warn", bus.warn_out, 0);

        rst = 1'b0;
        step();
        chk("idle_timer_rst", bus.timer_rst_out, 1);

        // Start: ARM one cycle, then RUN
        bus.start_in = 1'b1;
        step();
        bus.start_in = 1'b0;
        chk("arm_timer_rst", bus.timer_rst_out, 1);
        chk("arm_time_left", bus.time_left_out, 10);
        step();
        chk("run_timer_rst", bus.timer_rst_out, 0);
        chk("run_player", bus.player_out, 0);
        chk("run_time_left", bus.time_left_out, 10);

        // Countdown tracking and warning threshold
        bus.timer_count_in = 4'd6;
        step();
        chk("left_at_6", bus.time_left_out, 4);
        chk("warn_at_6", bus.warn_out, 0);
        bus.timer_count_in = 4'd7;
        step();
        chk("left_at_7", bus.time_left_out, 3);
        chk("warn_at_7", bus.warn_out, 4'(WarnEn));
        bus.timer_count_in = 4'd9;
        step();
        chk("left_at_9", bus.time_left_out, 1);

        // Player 0 moves
        bus.move_valid_in = 1'b1;
        step();
        bus.move_valid_in  = 1'b0;
        bus.timer_count_in = 4'd0;
        chk("sw_timer_rst", bus.timer_rst_out, 1);
        chk("sw_time_left", bus.time_left_out, 10);
        chk("sw_warn", bus.warn_out, 0);
        chk("sw_player", bus.player_out, 0);
        step();
        chk("arm2_player", bus.player_out, 1);
        chk("arm2_turn", bus.turn_count_out, 1);
        chk("arm2_timer_rst", bus.timer_rst_out, 1);
        step();
        chk("run2_timer_rst", bus.timer_rst_out, 0);

        // Player 1 times out -> auto move held until ack
        bus.timer_done_in = 1'b1;
        step();
        bus.timer_done_in = 1'b0;
        chk("auto_req", bus.auto_move_req_out, 1);
        chk("auto_timer_rst", bus.timer_rst_out, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("auto_hold", bus.auto_move_req_out, 1);
        end
        bus.auto_move_ack_in = 1'b1;
        step();
        bus.auto_move_ack_in = 1'b0;
        chk("ack_req_drop", bus.auto_move_req_out, 0);
        chk("ack_no_forfeit", bus.forfeit_out, 0);
        step();
        chk("ack_player", bus.player_out, 0);
        chk("ack_turn", bus.turn_count_out, 2);
        step();

        // Player 0 times out (streak 1), player 1 moves, player 0 times out again -> forfeit
        bus.timer_done_in = 1'b1;
        step();
        bus.timer_done_in = 1'b0;
        chk("p0_to1_auto", bus.auto_move_req_out, 1);
        bus.auto_move_ack_in = 1'b1;
        step();
        bus.auto_move_ack_in = 1'b0;
        step();
        step();
        chk("p1_turn_player", bus.player_out, 1);
        bus.move_valid_in = 1'b1;
        step();
        bus.move_valid_in = 1'b0;
        step();
        step();
        chk("p0_again_player", bus.player_out, 0);
        bus.timer_done_in = 1'b1;
        step();
        bus.timer_done_in = 1'b0;
        chk("forfeit", bus.forfeit_out, 1);
        chk("forfeit_winner", bus.winner_out, 1);
        chk("forfeit_no_req", bus.auto_move_req_out, 0);
        chk("forfeit_timer_rst", bus.timer_rst_out, 1);
        chk("forfeit_turn", bus.turn_count_out, 4);
        step();
        chk("done_hold", bus.forfeit_out, 1);

        // New game from DONE clears state
        bus.start_in = 1'b1;
        step();
        bus.start_in = 1'b0;
        chk("restart_forfeit", bus.forfeit_out, 0);
        chk("restart_turn", bus.turn_count_out, 0);
        chk("restart_player", bus.player_out, 0);
        step();

        // Give player 0 a streak of 1
        bus.timer_done_in = 1'b1;
        step();
        bus.timer_done_in    = 1'b0;
        bus.auto_move_ack_in = 1'b1;
        step();
        bus.auto_move_ack_in = 1'b0;
        step();
        step();
        bus.move_valid_in = 1'b1;
        step();
        bus.move_valid_in = 1'b0;
        step();
        step();

        // Move and timeout together: move wins, streak clears
        bus.move_valid_in = 1'b1;
        bus.timer_done_in = 1'b1;
        step();
        bus.move_valid_in = 1'b0;
        bus.timer_done_in = 1'b0;
        chk("both_no_req", bus.auto_move_req_out, 0);
        chk("both_switch_rst", bus.timer_rst_out, 1);
        step();
        chk("both_player", bus.player_out, 1);
        step();
        bus.move_valid_in = 1'b1;
        step();
        bus.move_valid_in = 1'b0;
        step();
        step();
        bus.timer_done_in = 1'b1;
        step();
        bus.timer_done_in = 1'b0;
        chk("streak_cleared_auto", bus.auto_move_req_out, 1);
        chk("streak_cleared_nofft", bus.forfeit_out, 0);

        // Asynchronous reset mid-AUTO
        step();
        #3;
        rst = 1'b1;
        #2;
        chk("async_rst_req", bus.auto_move_req_out, 0);
        chk("async_rst_timer", bus.timer_rst_out, 1);
        step();
        rst = 1'b0;
        step();

        // Turn count saturates at 9
        bus.start_in = 1'b1;
        step();
        bus.start_in = 1'b0;
        step();
        for (int i = 0; i < 11; i++) begin
            bus.move_valid_in = 1'b1;
            step();
            bus.move_valid_in = 1'b0;
            step();
            step();
        end
        chk("turn_sat", bus.turn_count_out, 9);

        // Game over in RUN ends without forfeit
        bus.game_over_in = 1'b1;
        step();
        bus.game_over_in = 1'b0;
        chk("gover_forfeit", bus.forfeit_out, 0);
        chk("gover_timer_rst", bus.timer_rst_out, 1);
        bus.move_valid_in = 1'b1;
        step();
        bus.move_valid_in = 1'b0;
        step();
        chk("done_ignores_move", bus.turn_count_out, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
